// File: rtl/req_pending_queue.sv
// Per-channel pending-request counters feeding a three-way arbiter.
// Optional starvation detection is built when REQ_PEND_STARVE_EN is defined.
module req_pending_queue #(
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p1,
    input  logic             p2,
    input  logic             p3,
    input  logic             a1,
    input  logic             a2,
    input  logic             a3,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [2:0]       ovf,
    output logic [2:0]       starve
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("req_pending_queue: TIMEOUT must be in 1..255");
    end

    logic [2:0]            w_p;
    logic [2:0]            w_a;
    logic [2:0]            w_r;
    logic [2:0]            w_ovf;
    logic [2:0]            w_starve;
    logic [2:0][CNT_W-1:0] w_cnt;

    assign w_p = {p3, p2, p1};
    assign w_a = {a3, a2, a1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_d;
        logic             r_ovf;
        logic             w_inc;
        logic             w_dec;
        logic             w_ovf_set;

        assign w_inc = w_p[gi];
        // A grant against an empty counter is ignored rather than wrapping.
        assign w_dec = w_a[gi] & (r_cnt != '0);

        always_comb begin
            w_cnt_d   = r_cnt;
            w_ovf_set = 1'b0;
            if (w_inc && !w_dec) begin
                if (r_cnt == CntMax) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end else if (!w_inc && w_dec) begin
                w_cnt_d = r_cnt - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_cnt <= w_cnt_d;
                r_ovf <= r_ovf | w_ovf_set;
            end
        end

        assign w_cnt[gi] = r_cnt;
        assign w_r[gi]   = (r_cnt != '0);
        assign w_ovf[gi] = r_ovf;

`ifdef REQ_PEND_STARVE_EN
        localparam logic [7:0] AgeLimit = 8'(TIMEOUT);

        logic [7:0] r_age;
        logic [7:0] w_age_d;
        logic       r_starve;

        // Age only while a request is visible to the arbiter and not being served.
        always_comb begin
            w_age_d = '0;
            if (w_r[gi] && !w_a[gi]) begin
                w_age_d = (r_age == AgeLimit) ? r_age : r_age + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_age    <= '0;
                r_starve <= 1'b0;
            end else begin
                r_age    <= w_age_d;
                r_starve <= r_starve | (w_age_d == AgeLimit);
            end
        end

        assign w_starve[gi] = r_starve;
`else
        assign w_starve[gi] = 1'b0;
`endif
    end

    assign r1     = w_r[0];
    assign r2     = w_r[1];
    assign r3     = w_r[2];
    assign cnt1   = w_cnt[0];
    assign cnt2   = w_cnt[1];
    assign cnt3   = w_cnt[2];
    assign ovf    = w_ovf;
    assign starve = w_starve;

endmodule

// File: tb/tb_req_pending_queue.sv
// Directed bench for req_pending_queue: an abstract per-channel model checked every
// cycle, plus hand-computed literal expectations along the test plan.
module tb_req_pending_queue;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TIMEOUT = 16;
    localparam int          MAX     = (1 << CNT_W) - 1;
`ifdef REQ_PEND_STARVE_EN
    localparam logic [2:0] StarveExp = 3'b010;
`else
    localparam logic [2:0] StarveExp = 3'b000;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    logic             a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
    logic             r1, r2, r3;
    logic [CNT_W-1:0] cnt1, cnt2, cnt3;
    logic [2:0]       ovf, starve;

    int errors = 0;
    int checks = 0;

    req_pending_queue #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .p1     (p1),
        .p2     (p2),
        .p3     (p3),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .r1     (r1),
        .r2     (r2),
        .r3     (r3),
        .cnt1   (cnt1),
        .cnt2   (cnt2),
        .cnt3   (cnt3),
        .ovf    (ovf),
        .starve (starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending requests as plain integers, flags as bit sets.
    int       m_cnt [3];
    int       m_age [3];
    bit [2:0] m_ovf;
    bit [2:0] m_starve;
    bit       m_valid = 1'b0;
    bit [2:0] m_p, m_a;
    bit       m_busy, m_take;

    always @(posedge clk) begin
        m_p = {p3, p2, p1};
        m_a = {a3, a2, a1};
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                m_age[i] = 0;
            end
            m_ovf    = '0;
            m_starve = '0;
            m_valid  = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_busy = (m_cnt[i] > 0);
                m_take = m_a[i] && m_busy;
                if (m_p[i] && !m_take) begin
                    if (m_cnt[i] == MAX) m_ovf[i] = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end else if (!m_p[i] && m_take) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
`ifdef REQ_PEND_STARVE_EN
                if (m_busy && !m_a[i]) begin
                    if (m_age[i] < TIMEOUT) m_age[i] = m_age[i] + 1;
                    if (m_age[i] == TIMEOUT) m_starve[i] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_cnt1", int'(cnt1), m_cnt[0]);
            chk("model_cnt2", int'(cnt2), m_cnt[1]);
            chk("model_cnt3", int'(cnt3), m_cnt[2]);
            chk("model_r", int'({r3, r2, r1}),
                int'({m_cnt[2] != 0, m_cnt[1] != 0, m_cnt[0] != 0}));
            chk("model_ovf", int'(ovf), int'(m_ovf));
            chk("model_starve", int'(starve), int'(m_starve));
        end
    end

    task automatic cyc(input logic [2:0] p, input logic [2:0] a, input logic rs);
        {p3, p2, p1} = p;
        {a3, a2, a1} = a;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(3'b000, 3'b000, 1'b1);
        cyc(3'b111, 3'b000, 1'b1);
        chk("reset_cnt", int'({cnt3, cnt2, cnt1}), 0);
        chk("reset_r", int'({r3, r2, r1}), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_starve", int'(starve), 0);

        // Single request and retire
        cyc(3'b001, 3'b000, 1'b0);
        chk("single_cnt1", int'(cnt1), 1);
        chk("single_r1", int'(r1), 1);
        cyc(3'b000, 3'b001, 1'b0);
        chk("retire_cnt1", int'(cnt1), 0);
        chk("retire_r1", int'(r1), 0);

        // Burst of three, then held grant
        for (int i = 0; i < 3; i++) cyc(3'b010, 3'b000, 1'b0);
        chk("burst_cnt2", int'(cnt2), 3);
        cyc(3'b000, 3'b010, 1'b0);
        chk("grant1_cnt2", int'(cnt2), 2);
        cyc(3'b000, 3'b010, 1'b0);
        chk("grant2_cnt2", int'(cnt2), 1);
        cyc(3'b000, 3'b010, 1'b0);
        chk("grant3_cnt2", int'(cnt2), 0);
        chk("grant3_r2", int'(r2), 0);

        // Overflow on channel 3
        for (int i = 0; i < 9; i++) cyc(3'b100, 3'b000, 1'b0);
        chk("ovf_cnt3", int'(cnt3), 7);
        chk("ovf_flag", int'(ovf), 3'b100);
        cyc(3'b100, 3'b100, 1'b0);
        chk("incdec_at_max_cnt3", int'(cnt3), 7);
        cyc(3'b000, 3'b000, 1'b0);
        chk("ovf_hold_cnt3", int'(cnt3), 7);
        chk("ovf_hold_flag", int'(ovf), 3'b100);

        // Spurious grant and simultaneous pulses
        cyc(3'b000, 3'b001, 1'b0);
        chk("spurious_cnt1", int'(cnt1), 0);
        cyc(3'b111, 3'b000, 1'b0);
        chk("simul_r", int'({r3, r2, r1}), 3'b111);
        chk("simul_cnt1", int'(cnt1), 1);
        chk("simul_cnt2", int'(cnt2), 1);
        chk("simul_cnt3", int'(cnt3), 7);

        // Drive channel 1 to overflow then back to 4, then reset with a pulse present
        for (int i = 0; i < 7; i++) cyc(3'b001, 3'b000, 1'b0);
        chk("ch1_full", int'(cnt1), 7);
        chk("ch1_ovf", int'(ovf), 3'b101);
        for (int i = 0; i < 3; i++) cyc(3'b000, 3'b001, 1'b0);
        chk("ch1_four", int'(cnt1), 4);
        cyc(3'b001, 3'b000, 1'b1);
        chk("midreset_cnt", int'({cnt3, cnt2, cnt1}), 0);
        chk("midreset_r", int'({r3, r2, r1}), 0);
        chk("midreset_ovf", int'(ovf), 0);

        // Starvation on channel 2
        cyc(3'b010, 3'b000, 1'b0);
        chk("starve_setup_cnt2", int'(cnt2), 1);
        for (int i = 0; i < 15; i++) cyc(3'b000, 3'b000, 1'b0);
        chk("starve_after15", int'(starve), 0);
        cyc(3'b000, 3'b000, 1'b0);
        chk("starve_after16", int'(starve), int'(StarveExp));
        cyc(3'b000, 3'b010, 1'b0);
        chk("starve_after_grant_cnt2", int'(cnt2), 0);
        chk("starve_sticky", int'(starve), int'(StarveExp));

        cyc(3'b000, 3'b000, 1'b0);
        cyc(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
